// File: rtl/usiq_packet_sched.sv
// usiq_packet_sched
//
// Round-robin packet scheduler. Up to four receiver sample streams share the
// single upstream IQ FIFO. One stream is granted at a time, and exactly PKTLEN
// samples are moved from it as one packet. tlast marks the final sample and
// tuser carries the receiver index. A packet starts only when the FIFO can take
// the whole packet, so packets are never split, truncated or interleaved. The
// block runs in the FIFO write-clock domain.
//
// Ports
//   clk           write-domain clock
//   rst           synchronous active-high reset
//   enable        allow new packets to start
//   rx_tdata      NRX x 24-bit samples, stream i at [24i+23:24i]
//   rx_tvalid     per-stream valid
//   rx_tready     per-stream ready (only the granted stream can be ready)
//   fifo_wrusedw  FIFO write-side fill level (11 bits)
//   m_tdata       sample to FIFO
//   m_tvalid      FIFO write request
//   m_tready      FIFO ready
//   m_tlast       last sample of the packet
//   m_tuser       receiver index of the current packet
//   busy          high while a packet or its trailing gap is in progress
//   pkt_count     completed packets, wraps at 0xFFFF
module usiq_packet_sched #(
  parameter int NRX        = 4,
  parameter int PKTLEN     = 63,
  parameter int FIFO_DEPTH = 1024,
  parameter int MARGIN     = 12,
  parameter int GAPCYC     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [NRX*24-1:0] rx_tdata,
  input  logic [NRX-1:0]    rx_tvalid,
  output logic [NRX-1:0]    rx_tready,
  input  logic [10:0]       fifo_wrusedw,
  output logic [23:0]       m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic [1:0]        m_tuser,
  output logic              busy,
  output logic [15:0]       pkt_count
);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  localparam logic [11:0] SPACE_LIMIT = 12'(FIFO_DEPTH - MARGIN);
  localparam logic [11:0] PKTLEN12    = 12'(PKTLEN);
  localparam logic [7:0]  LAST_IDX    = 8'(PKTLEN - 1);
  localparam logic [2:0]  GAP_LOAD    = 3'(GAPCYC);
  localparam logic [1:0]  LAST_RESET  = 2'(NRX - 1);

  state_t      state;
  state_t      state_next;
  logic [1:0]  grant;
  logic [1:0]  last_grant;
  logic [1:0]  pick;
  logic [1:0]  cand;
  logic        pick_found;
  logic [7:0]  count;
  logic [2:0]  gap_cnt;
  logic        space_ok;
  logic        start;
  logic        handshake;
  logic [3:0]  valid4;
  logic [3:0]  ready4;
  logic [23:0] lane [4];

  // Stretch the stream inputs to four lanes so the grant index can always
  // select a lane directly, whatever NRX is. Unused lanes read as idle.
  always_comb begin
    valid4 = 4'(rx_tvalid);
    for (int i = 0; i < 4; i++) begin
      lane[i] = '0;
    end
    for (int i = 0; i < NRX; i++) begin
      lane[i] = rx_tdata[i*24 +: 24];
    end
  end

  // The sum is widened to 12 bits, so a nearly full FIFO can never wrap the
  // comparison and look empty.
  assign space_ok = ({1'b0, fifo_wrusedw} + PKTLEN12) <= SPACE_LIMIT;

  // Round-robin search starts at the stream after the last grant. It stops at
  // the first valid stream it finds.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int k = 1; k <= NRX; k++) begin
      cand = 2'((int'(last_grant) + k) % NRX);
      if (!pick_found && valid4[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  assign start     = enable & space_ok & pick_found;
  assign handshake = m_tvalid & m_tready;
  assign busy      = (state != IDLE);
  assign rx_tready = ready4[NRX-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and outputs. The stream is passed through combinationally in
  // BURST. Outside BURST every output toward the FIFO and the receivers is idle.
  always_comb begin
    state_next = state;
    m_tdata    = '0;
    m_tvalid   = 1'b0;
    m_tlast    = 1'b0;
    m_tuser    = '0;
    ready4     = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = BURST;
        end
      end
      BURST: begin
        m_tdata       = lane[grant];
        m_tvalid      = valid4[grant];
        m_tlast       = (count == LAST_IDX);
        m_tuser       = grant;
        ready4[grant] = m_tready;
        if (valid4[grant] && m_tready && (count == LAST_IDX)) begin
          state_next = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == 3'd1) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant bookkeeping, sample and gap counters, and completed-packet count.
  // last_grant resets to the highest stream, so stream 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= '0;
      last_grant <= LAST_RESET;
      count      <= '0;
      gap_cnt    <= '0;
      pkt_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            grant      <= pick;
            last_grant <= pick;
            count      <= '0;
          end
        end
        BURST: begin
          if (handshake) begin
            count <= count + 8'd1;
            if (m_tlast) begin
              pkt_count <= pkt_count + 16'd1;
              gap_cnt   <= GAP_LOAD;
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - 3'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
